// File: rtl/bus_fifo.sv
// bus_fifo: DEPTH-entry valid/ready FIFO feeding a BUS_WIDTH-wide consumer.
// Optional macro BUS_FIFO_BYPASS_EN adds a zero-latency path when the FIFO is empty.
module bus_fifo #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BUS_WIDTH-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BUS_WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]          CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]          CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]        PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]        PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [BUS_WIDTH-1:0] DATA_ZERO = {BUS_WIDTH{1'b0}};

    logic [BUS_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;

    logic                 empty_s;
    logic                 full_s;
    logic                 wr_en_s;
    logic                 rd_en_s;
    logic                 bypass_s;

    // Handshake decode and output steering from the registered count.
    always_comb begin
        empty_s  = (count_r == CNT_ZERO);
        full_s   = (count_r == CNT_FULL);
        wr_en_s  = in_valid && !full_s;
        rd_en_s  = !empty_s && out_ready;
        bypass_s = 1'b0;
`ifdef BUS_FIFO_BYPASS_EN
        // An empty FIFO hands the word straight through when the consumer is ready.
        if (empty_s && in_valid && out_ready) begin
            bypass_s = 1'b1;
            wr_en_s  = 1'b0;
        end else begin
            bypass_s = 1'b0;
        end
`endif
        in_ready  = !full_s;
        out_valid = !empty_s || bypass_s;
        level     = count_r;
        if (bypass_s) begin
            out_data = in_data;
        end else if (!empty_s) begin
            out_data = mem_r[rd_ptr_r];
        end else begin
            out_data = DATA_ZERO;
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointer and occupancy registers; pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fifo.sv
// Scoreboard testbench for bus_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_bus_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    level;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q [$];
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         bypass_en;

    bus_fifo #(.BUS_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a word on the input until the FIFO takes it (bounded).
    task automatic send_hold(input logic [W-1:0] d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %0h never accepted", d);
        end
        in_valid = 1'b0;
    endtask

    // Monitor / scoreboard: compare outputs with the model, then apply this cycle's events.
    always @(negedge clk) begin
        int n;
        logic byp;
        logic exp_valid;
        logic [W-1:0] exp_data;
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_level", level, 0);
        end else begin
            n = exp_q.size();
            byp = bypass_en && (n == 0) && in_valid && out_ready;
            exp_valid = (n != 0) || byp;
            exp_data  = byp ? in_data : ((n != 0) ? exp_q[0] : '0);
            check("in_ready", in_ready, (n != D));
            check("out_valid", out_valid, exp_valid);
            check("out_data", out_data, exp_data);
            check("level", level, n);
            if (prev_hold) check("stable_data", out_data, prev_data);
            prev_hold = exp_valid && !out_ready;
            prev_data = exp_data;
            if (n != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && n != D && !byp) exp_q.push_back(in_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BUS_FIFO_BYPASS_EN
        bypass_en = 1'b1;
`else
        bypass_en = 1'b0;
`endif
        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // Reset then idle
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // Fill to full, hold a fifth word, then drain
        for (int i = 0; i < 4; i++) send_hold(32'hA0 + i);
        check("full_level", level, 4);
        in_valid = 1'b1;
        in_data  = 32'hA4;
        check("full_not_ready", in_ready, 0);
        step();
        step();
        out_ready = 1'b1;
        send_hold(32'hA4);
        repeat (8) step();
        out_ready = 1'b0;

        // Simultaneous read and write while full
        for (int i = 0; i < 4; i++) send_hold(32'hB0 + i);
        in_valid  = 1'b1;
        in_data   = 32'hB4;
        out_ready = 1'b1;
        step();
        check("simul_full_level", level, 3);
        step();
        check("simul_next_level", level, 3);
        in_valid = 1'b0;
        repeat (6) step();

        // Wrap-around stream with random back-pressure
        for (int w = 0; w < 20; w++) begin
            logic acc;
            if ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            in_valid = 1'b1;
            in_data  = 32'(w);
            for (int k = 0; k < 50; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                acc = in_ready;
                step();
                if (acc) break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        // Fully random traffic
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        // Asynchronous reset with three words stored
        out_ready = 1'b0;
        send_hold(32'h11);
        send_hold(32'h22);
        send_hold(32'h33);
        check("pre_reset_level", level, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_level", level, 0);
        check("async_in_ready", in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        send_hold(32'h55);
        check("post_reset_head", out_data, 32'h55);
        out_ready = 1'b1;
        repeat (3) step();

        // Empty FIFO, word offered with consumer ready
        in_valid = 1'b1;
        in_data  = 32'h77;
        #1;
        check("byp_out_valid", out_valid, bypass_en);
        check("byp_out_data", out_data, bypass_en ? 32'h77 : 32'h0);
        check("byp_level", level, 0);
        step();
        in_valid = 1'b0;
        #1;
        check("byp_next_valid", out_valid, !bypass_en);
        check("byp_next_data", out_data, bypass_en ? 32'h0 : 32'h77);
        step();
        out_ready = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
